// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline stages and the stall/flush controller.
// The stages (master) raise stall requests and redirects. The controller
// (slave) answers with per-register stall/clear strobes and the redirect ack.
interface pipe_hazard_ctrl_if #(
   parameter int N_STAGES = 4
);

   logic [N_STAGES-1:0] i_stall_req;
   logic                i_redirect_valid;
   logic                o_redirect_ack;
   logic [N_STAGES:0]   o_stall;
   logic [N_STAGES:0]   o_clear;

   modport master (
      output i_stall_req,
      output i_redirect_valid,
      input  o_redirect_ack,
      input  o_stall,
      input  o_clear
   );

   modport slave (
      input  i_stall_req,
      input  i_redirect_valid,
      output o_redirect_ack,
      output o_stall,
      output o_clear
   );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the in-order pipeline.
// Register 0 is the PC and registers 1..N_STAGES are the inter-stage latches.
// When several stages request a stall, the oldest requesting stage wins.
// A branch redirect is acknowledged only when the stage that resolves it is not held.
// Counters and the stall watchdog are registered. Stall, clear and ack are combinational.
module pipe_hazard_ctrl #(
   parameter int N_STAGES    = 4,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16,
   parameter int WDOG_W      = 10,
   parameter int WDOG_LIMIT  = 1000
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rdy,
   input  logic                 i_cnt_clr,
   pipe_hazard_ctrl_if.slave    bus,
   output logic [CNT_W-1:0]     o_stall_cnt,
   output logic [CNT_W-1:0]     o_flush_cnt,
   output logic                 o_wdog_timeout
);

   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

   logic [N_STAGES:0]  w_kStall;
   logic [N_STAGES:0]  w_kClear;
   logic               w_anyReq;
   logic               w_blocksRedirect;
   logic               w_ack;
   logic [N_STAGES:0]  w_stall;
   logic [N_STAGES:0]  w_clear;

   logic [CNT_W-1:0]   r_stallCnt;
   logic [CNT_W-1:0]   r_flushCnt;
   logic [WDOG_W-1:0]  r_wdogCnt;
   logic               r_wdogTimeout;

   // Build the hold/bubble pattern of the oldest requester.
   // Scanning upward lets the highest set request index overwrite the younger ones.
   always_comb begin
      w_kStall         = '0;
      w_kClear         = '0;
      w_blocksRedirect = 1'b0;
      w_anyReq         = |bus.i_stall_req;
      for (int i = 0; i < N_STAGES; i++) begin
         if (bus.i_stall_req[i]) begin
            for (int j = 0; j <= N_STAGES; j++) begin
               w_kStall[j] = (j <= i);
               w_kClear[j] = (j == i + 1);
            end
            w_blocksRedirect = (i >= FLUSH_DEPTH);
         end
      end
   end

   // Final stall/clear/ack, in priority order: reset, then freeze, then redirect, then plain stall.
   // A redirect drops the younger stall because that instruction is on the wrong path.
   // The PC is released so that it can load the branch target.
   always_comb begin
      w_ack   = i_rdy & ~i_rst & bus.i_redirect_valid & ~w_blocksRedirect;
      w_stall = w_kStall;
      w_clear = w_kClear;
      if (i_rst) begin
         w_stall = '0;
         w_clear = '1;
      end else if (!i_rdy) begin
         w_stall = '1;
         w_clear = '0;
      end else if (w_ack) begin
         for (int j = 0; j <= FLUSH_DEPTH; j++) begin
            w_stall[j] = 1'b0;
            if (j >= 1) begin
               w_clear[j] = 1'b1;
            end
         end
      end
   end

   assign bus.o_stall        = w_stall;
   assign bus.o_clear        = w_clear;
   assign bus.o_redirect_ack = w_ack;

   // Performance counters and stall watchdog.
   // Everything freezes while rdy is low. cnt_clr wins over any increment in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
         r_stallCnt    <= '0;
         r_flushCnt    <= '0;
         r_wdogCnt     <= '0;
         r_wdogTimeout <= 1'b0;
      end else if (i_rdy) begin
         if (w_anyReq && !w_ack && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + 1'b1;
         end
         if (w_ack && (r_flushCnt != '1)) begin
            r_flushCnt <= r_flushCnt + 1'b1;
         end
         if (w_stall[0]) begin
            if (r_wdogCnt != '1) begin
               r_wdogCnt <= r_wdogCnt + 1'b1;
            end
            if (r_wdogCnt >= WDOG_LAST) begin
               r_wdogTimeout <= 1'b1;
            end
         end else begin
            r_wdogCnt <= '0;
         end
      end
   end

   assign o_stall_cnt    = r_stallCnt;
   assign o_flush_cnt    = r_flushCnt;
   assign o_wdog_timeout = r_wdogTimeout;

endmodule
